// File: rtl/arb_defs.sv
// Shared definitions for the round-robin arbiter slice.
// Sizes, FSM state encoding and an index-to-one-hot helper.
package arb_defs;

    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic logic [ARB_N-1:0] idx2oh(
        input logic [ARB_IDX_W-1:0] idx
    );
        idx2oh = {{(ARB_N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: first set bit of req scanning
// from ptr upward, wrapping 7 -> 0. Purely combinational.
import arb_defs::*;

module rr_pick8 (
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_IDX_W-1:0] win_id,
    output logic                 any
);

    logic [ARB_IDX_W-1:0] idx;

    // Scan farthest-first so the slot nearest ptr is written last and wins.
    always_comb begin
        win_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = ARB_N - 1; k >= 0; k--) begin
            idx = ptr + ARB_IDX_W'(k);
            if (req[idx]) begin
                win_id = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Registered 8-way round-robin arbiter with grant hold until release.
// Optional forced handoff after MAX_HOLD cycles: RR_ARBITER8_TIMEOUT_EN.
import arb_defs::*;

module rr_arbiter8 #(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ARB_N-1:0]     req,
    output logic [ARB_N-1:0]     gnt,
    output logic [ARB_IDX_W-1:0] gnt_id,
    output logic                 gnt_valid
);

    if (MAX_HOLD < 1 || MAX_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_cfg
        $error("rr_arbiter8: MAX_HOLD out of range for HOLD_W");
    end

    arb_state_t           state_q, state_d;
    logic [ARB_N-1:0]     gnt_q, gnt_d;
    logic [ARB_IDX_W-1:0] id_q, id_d;
    logic [ARB_IDX_W-1:0] ptr_q, ptr_d;

`ifdef RR_ARBITER8_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    logic [HOLD_W-1:0] cnt_q, cnt_d;
`endif

    logic [ARB_N-1:0]     pick_req;
    logic [ARB_IDX_W-1:0] win_id;
    logic                 any;
    logic                 own_req;
    logic                 take;

    // The current owner is masked out so a handoff never re-picks it.
    assign pick_req = req & ~gnt_q;
    assign own_req  = |(req & gnt_q);

    rr_pick8 u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .win_id (win_id),
        .any    (any)
    );

    // Next-state: grant on idle request, hold while owner asserts req,
    // hand off in the same decision when the owner releases.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
`ifdef RR_ARBITER8_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (any) take = 1'b1;
            end
            ARB_BUSY: begin
                if (!own_req) begin
                    if (any) begin
                        take = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end
`ifdef RR_ARBITER8_TIMEOUT_EN
                else if (cnt_q == HOLD_MAX && any) begin
                    take = 1'b1;
                end else if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (take) begin
            state_d = ARB_BUSY;
            gnt_d   = idx2oh(win_id);
            id_d    = win_id;
            ptr_d   = win_id + 1'b1;
`ifdef RR_ARBITER8_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end
    end

    // State register; reset drops any grant with no handoff.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
`ifdef RR_ARBITER8_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
`ifdef RR_ARBITER8_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8.
// Expected grants are hand-computed from the rotation rules.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    int total = 0;
    int bad   = 0;

    rr_arbiter8 #(
        .HOLD_W   (4),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_gnt(input string tag, input logic [7:0] g,
                           input logic [2:0] id, input logic v);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".id"}, 32'(gnt_id), 32'(id));
        chk({tag, ".vld"}, 32'(gnt_valid), 32'(v));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        @(negedge clk);
        step();
        step();
        chk_gnt("rst", 8'h00, 3'd0, 1'b0);

        // Release reset with all requesting: requester 0 first.
        rst_n = 1'b1;
        step();
        chk_gnt("first", 8'h01, 3'd0, 1'b1);

        // Rotation: each owner holds two cycles then releases.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] own;
            logic [7:0] nxt;
            own = 8'h01 << i;
            nxt = 8'h01 << ((i + 1) % 8);
            step();
            chk_gnt("rot.hold", own, 3'(i), 1'b1);
            req = 8'hFF & ~own;
            step();
            chk_gnt("rot.next", nxt, 3'((i + 1) % 8), 1'b1);
            req = 8'hFF;
        end

        // Go idle; gnt_id keeps last value.
        req = 8'h00;
        step();
        chk_gnt("idle", 8'h00, 3'd0, 1'b0);

        // Grant 5 so ptr becomes 6, then wrap to 0, then 2.
        req = 8'h20;
        step();
        chk_gnt("wrap.g5", 8'h20, 3'd5, 1'b1);
        req = 8'h05;
        step();
        chk_gnt("wrap.g0", 8'h01, 3'd0, 1'b1);
        req = 8'h04;
        step();
        chk_gnt("wrap.g2", 8'h04, 3'd2, 1'b1);

        // Hold/release: requester 4 holds for 20 cycles.
        req = 8'h10;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_gnt("hold", 8'h10, 3'd4, 1'b1);
        end
        req = 8'h00;
        step();
        chk_gnt("release", 8'h00, 3'd4, 1'b0);

        // Owner 3, then reset mid-grant.
        req = 8'h08;
        step();
        chk_gnt("own3", 8'h08, 3'd3, 1'b1);
        rst_n = 1'b0;
        step();
        chk_gnt("midrst", 8'h00, 3'd0, 1'b0);
        // ptr back at 0: 3 beats 5 (ptr 4 would have picked 5).
        rst_n = 1'b1;
        req   = 8'h28;
        step();
        chk_gnt("postrst", 8'h08, 3'd3, 1'b1);

        // Timeout scenario from a clean reset: requesters 1 and 5.
        rst_n = 1'b0;
        req   = 8'h00;
        step();
        rst_n = 1'b1;
        req   = 8'h22;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_gnt("to.own1", 8'h02, 3'd1, 1'b1);
        end
        step();
`ifdef RR_ARBITER8_TIMEOUT_EN
        chk_gnt("to.force5", 8'h20, 3'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_gnt("to.own5", 8'h20, 3'd5, 1'b1);
        end
        step();
        chk_gnt("to.back1", 8'h02, 3'd1, 1'b1);
`else
        chk_gnt("to.keep1", 8'h02, 3'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_gnt("to.keep1", 8'h02, 3'd1, 1'b1);
        end
`endif

        // Lone requester past the hold limit keeps the grant.
        req = 8'h00;
        step();
        chk_gnt("lone.idle", 8'h00, 3'd1, 1'b0);
        req = 8'h80;
        for (int i = 0; i < 12; i++) begin
            step();
            chk_gnt("lone", 8'h80, 3'd7, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: never let the run hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Registered round-robin arbiter that shares one datapath resource (register-file write port, memory port, or bus) among eight requesters. It sits between the requesting units and the shared resource. It grants exactly one requester at a time and holds the grant until that requester releases. Priority rotates so that no requester starves.

## Interface
- `HOLD_W`, default 4: width of the hold counter.
- `MAX_HOLD`, default 15: maximum consecutive grant cycles when the timeout feature is compiled in; legal range 1..2^HOLD_W-1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req` input 8: request vector; bit i is requester i; level-sensitive.
- `gnt` output 8: one-hot grant, registered; all zero when idle.
- `gnt_id` output 3: binary index of the granted requester; valid only when `gnt_valid` is 1.
- `gnt_valid` output 1: 1 when `gnt` is non-zero (OR-reduction of `gnt`).

## Operation
- Two states:
  - IDLE: no grant.
  - BUSY: one grant held.
- Reset (`rst_n`=0 at a clock edge):
  - `gnt`=8'h00, `gnt_id`=3'd0, `gnt_valid`=0.
  - Rotation pointer `ptr`=3'd0, so requester 0 has highest priority first.
  - Hold counter = 0; state = IDLE.
  - Reset takes priority over every other event, including mid-grant. A grant is dropped on the reset edge with no handoff.
- Priority pick: the winner is the first set bit of `req` scanning `ptr`, `ptr`+1, …, `ptr`+7, modulo 8 (index wraps 7→0).
- IDLE:
  - If any `req` bit is set, grant the winner, go to BUSY, and set `ptr` = winner+1 (mod 8).
  - Otherwise stay in IDLE.
- BUSY, owner's `req` still 1: keep the grant and increment the hold counter (saturating).
- BUSY, owner's `req` is 0:
  - If other requests are pending, grant the next winner in the same cycle's decision (no idle bubble) and reload the hold counter to 0.
  - Otherwise go to IDLE with `gnt`=0.
- `gnt_id` follows the granted index. It holds its last value in IDLE, but `gnt_valid`=0.
- A requester never sees its grant removed while it holds `req`, except on reset or timeout.
- `gnt` is always zero or one-hot; two bits set is a bug.

## Timing
- Latency: `req` seen at edge N produces `gnt` visible after edge N (one cycle). No combinational path from `req` to `gnt`.
- Release: owner drops `req` before edge N. After edge N, `gnt` has moved to the next requester or is zero.
- Simultaneous requests on the same edge: the one nearest `ptr` wins; the others wait.
- A single requester held continuously keeps the grant indefinitely unless timeout is enabled.
- A request pulse of one cycle while another requester owns the resource is not latched. A requester must hold `req` until granted.

## Configuration
- Macro: `RR_ARBITER8_TIMEOUT_EN`.
- Defined:
  - When the hold counter reaches `MAX_HOLD` and any other `req` bit is set, the owner loses the grant at the next edge even though its `req` is still 1.
  - The grant passes to the next winner from `ptr` and the counter reloads to 0.
  - If no other request is pending, the owner keeps the grant and the counter stays saturated.
- Undefined: the hold counter is not instantiated, and a grant ends only on release or reset.

## Structure
- Shared package/header `arb_defs`:
  - `ARB_N`=8, `ARB_IDX_W`=3.
  - State encodings `ARB_IDLE`=1'b0, `ARB_BUSY`=1'b1.
- Sub-module `rr_pick8`: combinational rotating-priority encoder. Inputs are `req[7:0]` and `ptr[2:0]`; outputs are `win_id[2:0]` and `any`. The top level holds only registers and the FSM.

## Test plan
- Reset: assert `rst_n`=0 with `req`=8'hFF -> `gnt`=0, `gnt_valid`=0. Release reset -> next cycle `gnt`=8'h01, `gnt_id`=0.
- Rotation: hold `req`=8'hFF and drop each owner after 2 cycles -> grants in order 0,1,…,7,0. Each handoff has no idle cycle.
- Wrap: with `ptr`=6, set `req`=8'h05 -> grant to requester 0 (index wraps past 7), then to 2.
- Hold/release: `req`=8'h10 for 20 cycles, then 0 -> `gnt`=8'h10 throughout, then `gnt`=0 and `gnt_valid`=0 one cycle after the drop.
- Reset mid-grant: owner 3 active, pulse `rst_n`=0 for one edge -> `gnt`=0 after that edge. Re-arbitration then starts from `ptr`=0.
- Timeout (macro defined, `MAX_HOLD`=4): requesters 1 and 5 both hold `req` -> requester 1 is granted for 5 cycles, then forced over to requester 5. With the macro undefined, requester 1 keeps the grant.
